// File: rtl/stopwatch_pkg.sv
// Shared mode encodings, field indices and elaboration helpers for the
// stopwatch control slice.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_PAUSE = 2'd1,
        MODE_ADJ   = 2'd2
    } mode_e;

    localparam int unsigned FIELD_SEC = 0;
    localparam int unsigned FIELD_MIN = 1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_repeat_cnt.sv
// Modulo-REPEAT enable counter with synchronous clear; tc marks the enable
// that wraps the count back to zero.
import stopwatch_pkg::*;

module stopwatch_repeat_cnt #(
    parameter int unsigned REPEAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CNT_W = (REPEAT > 1) ? clog2(REPEAT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(REPEAT - 1);

    logic [CNT_W-1:0] cnt;

    assign tc = en & ~clr & (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_mode_ctrl.sv
// Registered RUN/PAUSE/ADJ mode selector with pause-edge toggle, field
// select, blink masking and auto-repeat increment pulses.
import stopwatch_pkg::*;

module stopwatch_mode_ctrl #(
    parameter int unsigned NUM_FIELDS = 2,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned REPEAT     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pause,
    input  logic                  adj,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  adj_tick,
    input  logic                  blink_tick,
    output logic [1:0]            mode,
    output logic                  run_en,
    output logic [NUM_FIELDS-1:0] adj_field,
    output logic [NUM_FIELDS-1:0] adj_inc,
    output logic [NUM_FIELDS-1:0] blink_mask
);

    mode_e                 state_q, state_d;
    logic                  pause_q, paused_q, paused_d;
    logic [NUM_FIELDS-1:0] field_q, field_d, field_oh;
    logic [NUM_FIELDS-1:0] inc_q, inc_d;
    logic                  blink_q, blink_d;
    logic                  stay_adj, rpt_clr, rpt_tc;

    always_comb begin
        int unsigned idx;
        idx = FIELD_SEC;
        if (32'(sel) > NUM_FIELDS - 1) idx = NUM_FIELDS - 1;
        else                           idx = 32'(sel);
        field_oh = '0;
        for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
            field_oh[i] = (i == idx);
        end
    end

    always_comb begin
        paused_d = paused_q ^ (pause & ~pause_q);
        state_d  = MODE_RUN;
        if (adj)           state_d = MODE_ADJ;
        else if (paused_d) state_d = MODE_PAUSE;
        field_d  = adj ? field_oh : '0;
        stay_adj = (state_q == MODE_ADJ) && adj;
        blink_d  = stay_adj ? (blink_q ^ blink_tick) : 1'b0;
    end

    // Counting only while ADJ persists on an unchanged field guarantees the
    // pulse never lands on an exit cycle or on a freshly selected field.
    assign rpt_clr = ~stay_adj | (field_oh != field_q);
    assign inc_d   = rpt_tc ? field_q : '0;

    stopwatch_repeat_cnt #(.REPEAT(REPEAT)) u_rpt (
        .clk   (clk),
        .reset (reset),
        .clr   (rpt_clr),
        .en    (adj_tick),
        .tc    (rpt_tc)
    );

    always_ff @(posedge clk) begin
        pause_q <= pause;
        if (reset) begin
            state_q  <= MODE_RUN;
            paused_q <= 1'b0;
            field_q  <= '0;
            inc_q    <= '0;
            blink_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            paused_q <= paused_d;
            field_q  <= field_d;
            inc_q    <= inc_d;
            blink_q  <= blink_d;
        end
    end

    assign mode       = state_q;
    assign run_en     = (state_q == MODE_RUN);
    assign adj_field  = field_q;
    assign adj_inc    = inc_q;
    assign blink_mask = blink_q ? field_q : '0;

endmodule

// File: tb/tb_stopwatch_mode_ctrl.sv
// Directed and randomized checks of stopwatch_mode_ctrl against a
// behavioural model of the mode, repeat and blink rules.
module tb_stopwatch_mode_ctrl;

    localparam int unsigned NF = 2;
    localparam int unsigned SW = 2;
    localparam int unsigned R  = 2;

    logic          clk = 1'b0;
    logic          reset, pause, adj, adj_tick, blink_tick;
    logic [SW-1:0] sel;
    logic [1:0]    mode;
    logic          run_en;
    logic [NF-1:0] adj_field, adj_inc, blink_mask;

    int errors = 0;
    int checks = 0;

    // model: paused flag, last pause level, mode number, field index,
    // qualifying ticks since the field session began, blink ticks in ADJ
    bit m_paused, m_prev, m_inc;
    int m_mode, m_field, m_ticks, m_blinks;

    always #5 clk = ~clk;

    stopwatch_mode_ctrl #(.NUM_FIELDS(NF), .SEL_W(SW), .REPEAT(R)) dut (
        .clk        (clk),
        .reset      (reset),
        .pause      (pause),
        .adj        (adj),
        .sel        (sel),
        .adj_tick   (adj_tick),
        .blink_tick (blink_tick),
        .mode       (mode),
        .run_en     (run_en),
        .adj_field  (adj_field),
        .adj_inc    (adj_inc),
        .blink_mask (blink_mask)
    );

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int fsat(input logic [SW-1:0] s);
        return (int'(s) > int'(NF) - 1) ? int'(NF) - 1 : int'(s);
    endfunction

    task automatic model_step(input bit r, p, a, input logic [SW-1:0] s, input bit at, bt);
        int f;
        bit stay;
        if (r) begin
            m_paused = 0; m_prev = p; m_mode = 0; m_field = 0;
            m_ticks = 0; m_blinks = 0; m_inc = 0;
            return;
        end
        if (p && !m_prev) m_paused = !m_paused;
        m_prev = p;
        f = fsat(s);
        stay = (m_mode == 2) && a;
        if (stay && f == m_field) begin
            m_ticks += int'(at);
            m_inc = at && (m_ticks % int'(R) == 0);
            m_blinks += int'(bt);
        end else if (stay) begin
            m_ticks = 0; m_inc = 0;
            m_blinks += int'(bt);
        end else begin
            m_ticks = 0; m_inc = 0; m_blinks = 0;
        end
        m_mode  = a ? 2 : (m_paused ? 1 : 0);
        m_field = f;
    endtask

    task automatic cyc(input bit r, p, a, input logic [SW-1:0] s, input bit at, bt);
        logic [3:0] oh;
        reset = r; pause = p; adj = a; sel = s; adj_tick = at; blink_tick = bt;
        @(posedge clk);
        model_step(r, p, a, s, at, bt);
        #1;
        oh = 4'(1) << m_field;
        chk("mode", 4'(mode), 4'(m_mode));
        chk("run_en", 4'(run_en), 4'(m_mode == 0));
        chk("adj_field", 4'(adj_field), (m_mode == 2) ? oh : 4'h0);
        chk("adj_inc", 4'(adj_inc), m_inc ? oh : 4'h0);
        chk("blink_mask", 4'(blink_mask), (m_mode == 2 && m_blinks % 2 == 1) ? oh : 4'h0);
    endtask

    initial begin
        int pulses;
        bit rp, ra, rr;
        logic [SW-1:0] rs;

        // 1: pause held through reset release
        repeat (3) cyc(1, 1, 0, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0, 0, 0);
        chk("t1_mode", 4'(mode), 4'd0);
        chk("t1_run_en", 4'(run_en), 4'd1);

        // 2: two separate pause pulses
        repeat (2) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("t2_first_rise", 4'(mode), 4'd1);
        cyc(0, 1, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("t2_second_rise", 4'(mode), 4'd0);
        cyc(0, 1, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0);

        // 3: pause, then ADJ on field 1 with five ticks
        repeat (2) cyc(0, 1, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0);
        chk("t3_paused", 4'(mode), 4'd1);
        repeat (2) cyc(0, 0, 1, 1, 0, 0);
        chk("t3_adj", 4'(mode), 4'd2);
        chk("t3_field", 4'(adj_field), 4'b0010);
        pulses = 0;
        for (int k = 1; k <= 5; k++) begin
            cyc(0, 0, 1, 1, 1, 0);
            if (adj_inc == 2'b10) pulses++;
            chk("t3_inc_tick", 4'(adj_inc), (k % 2 == 0) ? 4'b0010 : 4'b0000);
            cyc(0, 0, 1, 1, 0, 0);
            if (adj_inc != 2'b00) pulses++;
        end
        chk("t3_pulse_count", 4'(pulses), 4'd2);

        // 4: pause edge during ADJ, then leave ADJ
        repeat (2) cyc(0, 1, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("t4_resume_run", 4'(mode), 4'd0);
        chk("t4_inc_exit", 4'(adj_inc), 4'd0);

        // 5: saturated select, then field change mid-count
        repeat (2) cyc(0, 0, 1, 3, 0, 0);
        chk("t5_sat_field", 4'(adj_field), 4'b0010);
        cyc(0, 0, 1, 3, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("t5_new_field", 4'(adj_field), 4'b0001);
        cyc(0, 0, 1, 0, 1, 0);
        chk("t5_no_pulse", 4'(adj_inc), 4'd0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 0);
        chk("t5_pulse", 4'(adj_inc), 4'b0001);

        // 6: blink, then reset mid-ADJ
        cyc(0, 0, 1, 0, 0, 1);
        chk("t6_blink1", 4'(blink_mask), 4'b0001);
        cyc(0, 0, 1, 0, 0, 1);
        chk("t6_blink2", 4'(blink_mask), 4'b0000);
        cyc(0, 0, 1, 0, 0, 1);
        chk("t6_blink3", 4'(blink_mask), 4'b0001);
        cyc(1, 0, 1, 0, 1, 1);
        chk("t6_rst_mode", 4'(mode), 4'd0);
        chk("t6_rst_field", 4'(adj_field), 4'd0);
        chk("t6_rst_blink", 4'(blink_mask), 4'd0);
        chk("t6_rst_inc", 4'(adj_inc), 4'd0);

        // randomized traffic against the model
        rp = 0; ra = 0; rs = 0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) rp = ~rp;
            if ($urandom_range(0, 11) == 0) ra = ~ra;
            if ($urandom_range(0, 9) == 0) rs = SW'($urandom);
            rr = ($urandom_range(0, 59) == 0);
            cyc(rr, rp, ra, rs, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_mode_ctrl.md
Name: stopwatch_mode_ctrl

Overview:
- Parametrised successor to the stopwatch mode selector.
- Turns the pause button, adj switch and sel switches into a registered mode: RUN, PAUSE or ADJ (field k).
- Adds pause-edge detection, a remembered pause state across ADJ, N selectable fields, blink masking and auto-repeat increment pulses.
- Sits between the debouncers/clock-enable dividers and the counter/display datapath.

Parameters:
- NUM_FIELDS, 2, number of adjustable display fields (>=2).
- SEL_W, 2, width of sel; must be >= clog2(NUM_FIELDS).
- REPEAT, 1, adj_tick enables per increment pulse in ADJ (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pause  in  1  debounced pause button level
- adj  in  1  adjust-mode switch level
- sel  in  SEL_W  field-select switches
- adj_tick  in  1  one-cycle enable, adjust rate (e.g. 2 Hz)
- blink_tick  in  1  one-cycle enable, blink rate (e.g. 4 Hz)
- mode  out  2  state encoding: RUN=0, PAUSE=1, ADJ=2
- run_en  out  1  high iff mode==RUN
- adj_field  out  NUM_FIELDS  one-hot selected field in ADJ, else 0
- adj_inc  out  NUM_FIELDS  one-cycle increment pulse to selected field
- blink_mask  out  NUM_FIELDS  fields to blank this cycle

Behaviour:
Clock and reset:
- One clock, clk. reset is synchronous and active-high.

Reset values:
- mode=RUN, paused_flag=0, blink_phase=0, repeat count=0.
- All outputs 0 except run_en=1.
- pause_q loads pause during reset, so a button held through reset causes no toggle.

Pause edge:
- pause_q <= pause every cycle.
- pause_rise = pause & ~pause_q.
- On pause_rise, paused_flag toggles.

State transitions (evaluated each cycle, result registered, visible the cycle after the sampling edge):
- adj==1: next=ADJ, regardless of paused_flag.
- adj==0 and paused_flag_next==1: next=PAUSE.
- adj==0 and paused_flag_next==0: next=RUN.
- Pause edges during ADJ still toggle paused_flag. On leaving ADJ the block resumes RUN or PAUSE according to the flag.
- A pause edge and an adj rise in the same cycle: the flag toggles and the state goes to ADJ.

Field select:
- field = min(sel, NUM_FIELDS-1), decoded one-hot.
- Registered with the state; adj_field is 0 outside ADJ.

Auto-repeat:
- In ADJ, each adj_tick increments rcnt.
- When rcnt==REPEAT-1 on an adj_tick, rcnt is set to 0 and adj_inc = adj_field for one cycle.
- With REPEAT=1, every adj_tick pulses.
- rcnt clears on ADJ entry, on a field change, and outside ADJ.
- adj_inc is registered: it appears the cycle after the qualifying adj_tick.
- adj_inc is never asserted outside ADJ, including on the ADJ-exit cycle.

Blink:
- blink_phase toggles on each blink_tick while in ADJ.
- Cleared on ADJ entry and outside ADJ.
- blink_mask = adj_field when blink_phase==1, else 0.

Reset mid-operation:
- reset overrides everything in the same cycle. Outputs reach their reset values on the next edge.

Decomposition:
- Package stopwatch_pkg holds:
  - mode encodings MODE_RUN, MODE_PAUSE, MODE_ADJ (2-bit);
  - a clog2 helper function;
  - the field index constants FIELD_SEC=0 and FIELD_MIN=1.
- One sub-module, stopwatch_repeat_cnt: a REPEAT-modulo enable counter with sync clear, emitting a terminal pulse.
- FSM, edge detect, field decode and blink stay in the top module.

Test Plan:
1. Reset with pause=1 held, then release reset with pause still 1 -> mode stays 0 and run_en=1; no toggle.
2. Two separate pause pulses (20 ns high, 20 ns low each) -> mode 0->1 one cycle after the first rise, then 1->0 after the second rise.
3. One pause pulse (mode=1), then adj=1 with sel=1, NUM_FIELDS=2, REPEAT=2, five adj_ticks -> mode=2, adj_field=2'b10, adj_inc=2'b10 after ticks 2 and 4 only.
4. In ADJ, pulse pause once, then adj=0 -> flag toggled to 0, so mode returns to 0 (RUN), not 1.
5. In ADJ with sel=3, NUM_FIELDS=2 -> adj_field=2'b10 (saturated). Change sel to 0 mid-count -> adj_field=2'b01, rcnt cleared, next pulse after REPEAT further ticks.
6. In ADJ, three blink_ticks -> blink_mask alternates selected field/0/selected field. Assert reset mid-ADJ -> next cycle mode=0, adj_field=0, blink_mask=0, adj_inc=0.
